// File: rtl/serv_dbus_pkg.sv
// Shared types and constants for the SERV dbus responder.
//   state_e    : responder FSM encoding (IDLE/WAIT/ACK)
//   wb_req_t   : captured write-enable, byte selects and write data of one access
//   lane_merge : overlays selected byte lanes of a new word onto an old word
package serv_dbus_pkg;

    localparam int unsigned WAIT_CNT_W = 4;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned SEL_W      = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_e;

    typedef struct packed {
        logic              we;
        logic [SEL_W-1:0]  sel;
        logic [DATA_W-1:0] dat;
    } wb_req_t;

    function automatic logic [DATA_W-1:0] lane_merge(
        input logic [DATA_W-1:0] old_w,
        input logic [DATA_W-1:0] new_w,
        input logic [SEL_W-1:0]  sel
    );
        logic [DATA_W-1:0] m;
        m = old_w;
        for (int unsigned b = 0; b < SEL_W; b++) begin
            if (sel[b]) m[8*b +: 8] = new_w[8*b +: 8];
        end
        return m;
    endfunction

endpackage

// File: rtl/serv_dbus_ram.sv
// Synchronous byte-lane RAM, MEM_DEPTH x 32, registered write-first read port.
//   clk_i, rst_i : clock, async active-high reset (read register only; array is not reset)
//   addr_i       : word index shared by read and write
//   we_i         : per-byte write enables
//   wdata_i      : write data
//   re_i         : load read register from the array
//   clr_i        : zero the read register (when re_i is low)
//   rdata_o      : registered read data, held between loads
module serv_dbus_ram
    import serv_dbus_pkg::*;
#(
    parameter int unsigned MEM_DEPTH = 256,
    parameter int unsigned AW        = $clog2(MEM_DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [AW-1:0]     addr_i,
    input  logic [SEL_W-1:0]  we_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic              clr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [MEM_DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Byte-lane write
    always_ff @(posedge clk_i) begin
        for (int unsigned b = 0; b < SEL_W; b++) begin
            if (we_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
    end

    // Read register; a same-edge write shows through on its lanes
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= lane_merge(mem_q[addr_i], wdata_i, we_i);
        end else if (clr_i) begin
            rdata_q <= '0;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/serv_dbus_resp.sv
// Wishbone-classic data-bus responder for the SERV core: word RAM with byte lanes,
// WAIT_CYCLES wait states between request capture and a single-cycle ack.
//   i_clk, i_rst          : clock, async active-high reset
//   i_wb_cyc/we/sel/adr/dat : initiator request (byte address, [1:0] ignored)
//   o_wb_rdt              : read data, valid in ack cycle, held until next read ack
//   o_wb_ack              : one-cycle completion pulse
//   o_busy                : high whenever the FSM is not idle
//   o_err                 : out-of-range pulse in the ack cycle
// Optional feature: define SERV_DBUS_BOUNDS_EN to flag addresses above the RAM as
// out of range (write suppressed, read returns 0, o_err pulses). Without it the
// address aliases modulo MEM_DEPTH and o_err stays 0.
module serv_dbus_resp
    import serv_dbus_pkg::*;
#(
    parameter int unsigned MEM_DEPTH   = 256,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_wb_cyc,
    input  logic        i_wb_we,
    input  logic [3:0]  i_wb_sel,
    input  logic [31:0] i_wb_adr,
    input  logic [31:0] i_wb_dat,
    output logic [31:0] o_wb_rdt,
    output logic        o_wb_ack,
    output logic        o_busy,
    output logic        o_err
);

    localparam int unsigned AW = $clog2(MEM_DEPTH);
    localparam logic [WAIT_CNT_W-1:0] WAIT_INIT = WAIT_CNT_W'(WAIT_CYCLES);

    state_e                state_q, state_d;
    logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
    wb_req_t               req_q, req_d;
    logic [AW-1:0]         idx_q, idx_d;
    logic                  oob_q, oob_d;
    logic                  ack_q, busy_q, err_q;
    logic                  blank_q;

    logic                  in_oob_c;
    logic [SEL_W-1:0]      ram_we_c;
    logic                  ram_re_c;
    logic                  ram_clr_c;
    logic                  unused_c;

`ifdef SERV_DBUS_BOUNDS_EN
    assign in_oob_c = |i_wb_adr[31:AW+2];
    assign unused_c = ^i_wb_adr[1:0];
`else
    assign in_oob_c = 1'b0;
    assign unused_c = ^{i_wb_adr[31:AW+2], i_wb_adr[1:0]};
`endif

    // Next-state: capture in IDLE, count down in WAIT, single ACK cycle
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        idx_d   = idx_q;
        oob_d   = oob_q;
        case (state_q)
            ST_IDLE: begin
                // blank_q: cyc still high right after an ack is the old request
                if (i_wb_cyc && !blank_q) begin
                    req_d.we  = i_wb_we;
                    req_d.sel = i_wb_sel;
                    req_d.dat = i_wb_dat;
                    idx_d     = i_wb_adr[AW+1:2];
                    oob_d     = in_oob_c;
                    cnt_d     = WAIT_INIT;
                    state_d   = (WAIT_CYCLES == 0) ? ST_ACK : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!i_wb_cyc) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - WAIT_CNT_W'(1);
                    if (cnt_q == WAIT_CNT_W'(1)) state_d = ST_ACK;
                end
            end
            ST_ACK:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Read loads on the edge entering ACK; write commits on the edge leaving ACK
    assign ram_re_c  = (state_d == ST_ACK) && !req_d.we && !oob_d;
    assign ram_clr_c = (state_d == ST_ACK) && !req_d.we && oob_d;
    assign ram_we_c  = ((state_q == ST_ACK) && req_q.we && !oob_q) ? req_q.sel : '0;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            req_q   <= '0;
            idx_q   <= '0;
            oob_q   <= 1'b0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            blank_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            idx_q   <= idx_d;
            oob_q   <= oob_d;
            ack_q   <= (state_d == ST_ACK);
            busy_q  <= (state_d != ST_IDLE);
            err_q   <= (state_d == ST_ACK) && oob_d;
            blank_q <= ack_q;
        end
    end

    serv_dbus_ram #(
        .MEM_DEPTH (MEM_DEPTH),
        .AW        (AW)
    ) u_ram (
        .clk_i   (i_clk),
        .rst_i   (i_rst),
        .addr_i  (idx_d),
        .we_i    (ram_we_c),
        .wdata_i (req_q.dat),
        .re_i    (ram_re_c),
        .clr_i   (ram_clr_c),
        .rdata_o (o_wb_rdt)
    );

    assign o_wb_ack = ack_q;
    assign o_busy   = busy_q;
    assign o_err    = err_q;

endmodule

// File: tb/tb_serv_dbus_resp.sv
// Bench for serv_dbus_resp: two instances (WAIT_CYCLES 0 and 3) driven by directed
// and random accesses, checked against a word-array reference model.
module tb_serv_dbus_resp;

    logic        clk = 1'b0;
    logic        rst;
    logic        cyc [2];
    logic        we  [2];
    logic [3:0]  sel [2];
    logic [31:0] adr [2];
    logic [31:0] dat [2];
    logic [31:0] rdt [2];
    logic        ack [2];
    logic        busy[2];
    logic        err [2];

    int n_tests = 0;
    int n_fail  = 0;

    int unsigned waits [2] = '{0, 3};

    logic [31:0] mem_m    [2][256];
    logic [31:0] last_rdt [2];

    always #5 clk = ~clk;

    serv_dbus_resp #(.MEM_DEPTH(256), .WAIT_CYCLES(0)) dut0 (
        .i_clk(clk), .i_rst(rst), .i_wb_cyc(cyc[0]), .i_wb_we(we[0]), .i_wb_sel(sel[0]),
        .i_wb_adr(adr[0]), .i_wb_dat(dat[0]), .o_wb_rdt(rdt[0]), .o_wb_ack(ack[0]),
        .o_busy(busy[0]), .o_err(err[0])
    );

    serv_dbus_resp #(.MEM_DEPTH(256), .WAIT_CYCLES(3)) dut3 (
        .i_clk(clk), .i_rst(rst), .i_wb_cyc(cyc[1]), .i_wb_we(we[1]), .i_wb_sel(sel[1]),
        .i_wb_adr(adr[1]), .i_wb_dat(dat[1]), .o_wb_rdt(rdt[1]), .o_wb_ack(ack[1]),
        .o_busy(busy[1]), .o_err(err[1])
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: word array per instance, upper address bits alias or flag out of range
    task automatic model(input int w, input logic wr, input logic [31:0] a, input logic [3:0] s,
                         input logic [31:0] d, output logic [31:0] er, output logic ee);
        logic        oob;
        int          idx;
        logic [31:0] word;
`ifdef SERV_DBUS_BOUNDS_EN
        oob = ((a >> 10) != 0);
`else
        oob = 1'b0;
`endif
        idx = int'((a >> 2) % 256);
        if (wr) begin
            if (!oob) begin
                word = mem_m[w][idx];
                for (int b = 0; b < 4; b++) if (s[b]) word[8*b +: 8] = d[8*b +: 8];
                mem_m[w][idx] = word;
            end
            er = last_rdt[w];
        end else begin
            er = oob ? 32'h0 : mem_m[w][idx];
            last_rdt[w] = er;
        end
        ee = oob;
    endtask

    // One full access; called right after a negedge, returns at a negedge with cyc low
    task automatic access(input int w, input logic wr, input logic [31:0] a, input logic [3:0] s,
                          input logic [31:0] d, input bit hold, input string tag,
                          output logic [31:0] obs);
        logic [31:0] er;
        logic        ee;
        int          lat;
        bit          got;
        model(w, wr, a, s, d, er, ee);
        cyc[w] = 1'b1; we[w] = wr; adr[w] = a; sel[w] = s; dat[w] = d;
        lat = 0; got = 0; obs = 32'h0;
        while (!got && lat < 32) begin
            @(negedge clk);
            lat++;
            if (ack[w]) got = 1;
            else chk({tag, ".busy_wait"}, 32'(busy[w]), 32'd1);
        end
        chk({tag, ".latency"}, 32'(lat), 32'(waits[w] + 1));
        if (got) begin
            obs = rdt[w];
            chk({tag, ".rdt"}, rdt[w], er);
            chk({tag, ".err"}, 32'(err[w]), 32'(ee));
            chk({tag, ".busy_ack"}, 32'(busy[w]), 32'd1);
        end
        if (!hold) cyc[w] = 1'b0;
        @(negedge clk);
        chk({tag, ".ack_width"}, 32'(ack[w]), 32'd0);
        chk({tag, ".busy_after"}, 32'(busy[w]), 32'd0);
        cyc[w] = 1'b0;
        @(negedge clk);
        chk({tag, ".no_reack"}, 32'(ack[w]), 32'd0);
        chk({tag, ".idle"}, 32'(busy[w]), 32'd0);
    endtask

    initial begin
        logic [31:0] obs;
        logic [31:0] a, up, d;
        logic [3:0]  s;
        logic        wr;
        int          w, idx;
        bit          hold;

        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cyc[i] = 1'b0; we[i] = 1'b0; sel[i] = 4'h0; adr[i] = 32'h0; dat[i] = 32'h0;
            last_rdt[i] = 32'h0;
        end
        repeat (2) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("reset.ack", 32'(ack[i]), 32'd0);
            chk("reset.busy", 32'(busy[i]), 32'd0);
            chk("reset.rdt", rdt[i], 32'h0);
            chk("reset.err", 32'(err[i]), 32'd0);
        end
        rst = 1'b0;
        @(negedge clk);

        // Zero-wait write then read
        access(0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 0, "t1.wr", obs);
        access(0, 1'b0, 32'h10, 4'h0, 32'h0, 0, "t1.rd", obs);
        chk("t1.const", obs, 32'hDEADBEEF);

        // Byte lanes
        access(0, 1'b1, 32'h14, 4'hF, 32'h11223344, 0, "t2.wr", obs);
        access(0, 1'b1, 32'h14, 4'b0101, 32'hAABBCCDD, 0, "t2.wrsel", obs);
        access(0, 1'b0, 32'h16, 4'h3, 32'h0, 0, "t2.rd", obs);
        chk("t2.const", obs, 32'h11BB33DD);

        // sel==0 write leaves RAM alone
        access(0, 1'b1, 32'h10, 4'h0, 32'hFFFFFFFF, 0, "sel0.wr", obs);
        access(0, 1'b0, 32'h10, 4'hF, 32'h0, 0, "sel0.rd", obs);
        chk("sel0.const", obs, 32'hDEADBEEF);

        // cyc held one cycle past ack is not a new request
        access(0, 1'b0, 32'h14, 4'hF, 32'h0, 1, "hold", obs);

        // Three wait states
        access(1, 1'b1, 32'h20, 4'hF, 32'h12345678, 0, "t3.wr", obs);
        access(1, 1'b0, 32'h20, 4'hF, 32'h0, 0, "t3.rd", obs);
        chk("t3.const", obs, 32'h12345678);

        // Abort in WAIT: no ack, no write, rdt unchanged
        cyc[1] = 1'b1; we[1] = 1'b1; adr[1] = 32'h20; sel[1] = 4'hF; dat[1] = 32'h55;
        repeat (2) begin
            @(negedge clk);
            chk("t4.ack_pre", 32'(ack[1]), 32'd0);
        end
        cyc[1] = 1'b0;
        repeat (6) begin
            @(negedge clk);
            chk("t4.ack_post", 32'(ack[1]), 32'd0);
        end
        chk("t4.busy", 32'(busy[1]), 32'd0);
        chk("t4.rdt", rdt[1], 32'h12345678);
        access(1, 1'b0, 32'h20, 4'hF, 32'h0, 0, "t4.rd", obs);
        chk("t4.const", obs, 32'h12345678);

        // Reset mid-WAIT
        cyc[1] = 1'b1; we[1] = 1'b0; adr[1] = 32'h10; sel[1] = 4'hF;
        repeat (2) @(negedge clk);
        chk("t5.busy_pre", 32'(busy[1]), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("t5.ack", 32'(ack[1]), 32'd0);
        chk("t5.busy", 32'(busy[1]), 32'd0);
        chk("t5.rdt", rdt[1], 32'h0);
        chk("t5.rdt0", rdt[0], 32'h0);
        last_rdt[0] = 32'h0; last_rdt[1] = 32'h0;
        cyc[1] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        access(1, 1'b0, 32'h20, 4'hF, 32'h0, 0, "t5.rd", obs);
        chk("t5.const", obs, 32'h12345678);

        // Upper address bits: alias, or out of range when bounds checking is built in
        access(0, 1'b1, 32'h000, 4'hF, 32'hCAFEF00D, 0, "t6.wr0", obs);
        access(0, 1'b1, 32'h400, 4'hF, 32'h0BADBEEF, 0, "t6.wr400", obs);
        access(0, 1'b0, 32'h000, 4'hF, 32'h0, 0, "t6.rd0", obs);
`ifdef SERV_DBUS_BOUNDS_EN
        chk("t6.const0", obs, 32'hCAFEF00D);
`else
        chk("t6.const0", obs, 32'h0BADBEEF);
`endif
        access(0, 1'b0, 32'h400, 4'hF, 32'h0, 0, "t6.rd400", obs);
`ifdef SERV_DBUS_BOUNDS_EN
        chk("t6.const400", obs, 32'h0);
`else
        chk("t6.const400", obs, 32'h0BADBEEF);
`endif

        // Random traffic over a small pre-filled window
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 16; j++) begin
                access(i, 1'b1, 32'(j * 4), 4'hF, $urandom, 0, "fill", obs);
            end
        end
        for (int n = 0; n < 80; n++) begin
            w    = int'($urandom_range(0, 1));
            wr   = 1'($urandom_range(0, 1));
            idx  = int'($urandom_range(0, 15));
            up   = ($urandom_range(0, 3) == 0) ? $urandom : 32'h0;
            a    = (up << 10) | 32'(idx * 4) | 32'($urandom_range(0, 3));
            s    = 4'($urandom_range(0, 15));
            d    = $urandom;
            hold = ($urandom_range(0, 7) == 0);
            access(w, wr, a, s, d, hold, "rand", obs);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
